// File: rtl/logic_basic_cdc_pkg.sv
// Shared definitions for the toggle request/acknowledge CDC link.
// The state type is common to the transmitter and the receiver.
package logic_basic_cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_tx_state_t;

  // Fewer than two flops leaves no settling time for a metastable first stage.
  localparam int CDC_MIN_STAGES = 2;

endpackage

// File: rtl/logic_basic_cdc_transmitter_synchronizer.sv
// Multi-flop level synchronizer that brings an asynchronous signal into the aclk domain.
module logic_basic_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // NOTE: the stages are reset as well, so after reset the output is a known 0
  // rather than whatever the chain powered up with.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/logic_basic_cdc_transmitter.sv
// Source half of a toggle req/ack CDC link: captures one word, toggles cdc_req,
// and waits for the synchronized cdc_ack toggle before accepting the next word.
module logic_basic_cdc_transmitter
  import logic_basic_cdc_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             cdc_req,
  output logic [WIDTH-1:0] cdc_data,
  input  logic             cdc_ack,
  output logic             err
);

  if (STAGES < CDC_MIN_STAGES) begin : g_stages_check
    $error("logic_basic_cdc_transmitter: STAGES must be at least %0d", CDC_MIN_STAGES);
  end

  cdc_tx_state_t    state_q;
  logic             req_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic             ack_s;

  logic_basic_synchronizer #(
    .WIDTH  (1),
    .STAGES (STAGES)
  ) u_ack_sync (
    .aclk     (aclk),
    .areset_n (areset_n),
    .d_i      (cdc_ack),
    .q_o      (ack_s)
  );

  // NOTE: non-blocking assignments everywhere here, so every branch sees the
  // pre-edge value of req_q regardless of statement order.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // In IDLE the echoed toggle must already match; anything else is a stray ack.
          if (ack_s != req_q) begin
            err_q <= 1'b1;
          end
          if (tx_valid) begin
            data_q  <= tx_data;
            req_q   <= ~req_q;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == req_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign cdc_req  = req_q;
  assign cdc_data = data_q;
  assign err      = err_q;

endmodule

// File: doc/logic_basic_cdc_transmitter.md
# logic_basic_cdc_transmitter

Source-domain half of a toggle-based request/acknowledge clock-domain-crossing link. Accepts one data word at a time over a valid/ready handshake and holds it stable on `cdc_data`. It signals the word by toggling `cdc_req`, then waits for the destination domain's `cdc_ack` toggle, which it synchronizes internally, before accepting the next word. It pairs with a destination-side receiver that samples `cdc_data` when its synchronized `cdc_req` changes and echoes the toggle on `cdc_ack`.

## Interface
- `WIDTH`, 1, bits of `tx_data`/`cdc_data`
- `STAGES`, 2, flip-flop stages of the `cdc_ack` synchronizer; legal values ≥ 2

- `aclk` input 1 source-domain clock
- `areset_n` input 1 reset, asynchronous, active-low
- `tx_valid` input 1 source offers a word
- `tx_ready` output 1 block can accept a word
- `tx_data` input WIDTH word to transfer
- `cdc_req` output 1 request toggle, registered, toward the destination domain
- `cdc_data` output WIDTH registered data, stable while a transfer is outstanding
- `cdc_ack` input 1 acknowledge toggle from the destination domain, asynchronous to `aclk`
- `err` output 1 sticky protocol-error flag

## Operation
- Reset values: `tx_ready`=1, `cdc_req`=0, `cdc_data`='0, `err`=0, state IDLE, synchronizer stages all 0.
- Handshake: a transfer occurs when `tx_valid && tx_ready` at a rising edge. `tx_valid` may be held high across transfers.
- `ack_s` is the synchronized `cdc_ack`, taken from the last synchronizer stage.
- State machine, with `tx_ready` = (state == IDLE) taken from registered state only:
  - IDLE: on a transfer, `cdc_data` <= `tx_data` and `cdc_req` <= ~`cdc_req`; go to WAIT_ACK.
  - WAIT_ACK: `cdc_data` and `cdc_req` hold. When `ack_s == cdc_req`, go to IDLE. No other exit besides reset.
- Protocol error: `err` <= 1 whenever state is IDLE and `ack_s != cdc_req`. This covers a spurious ack toggle, or a destination that was not reset together with the source. `err` clears only on reset.
- Transfers continue normally while `err` is set.
- Mid-operation reset: an outstanding transfer is abandoned, and all outputs take reset values immediately, asynchronously.
- The destination must also be reset, so that `cdc_ack` returns to 0. Otherwise `err` asserts STAGES+1 edges after reset release.
- `cdc_data` changes only at the accepting edge, and only while `ack_s == cdc_req`. A receiver sampling on its synchronized req edge therefore always sees stable data.

## Timing
- Accept at edge E: at E+0, `cdc_req` toggles, `cdc_data` updates and `tx_ready` falls.
- Let edge A be the first `aclk` edge that samples the new `cdc_ack` level.
  - `ack_s` changes at A+STAGES−1.
  - `tx_ready` rises at edge A+STAGES.
- Minimum throughput: one word per (2 + destination turnaround + STAGES) `aclk` cycles. There is no back-to-back acceptance.
- No combinational path from any input to any output.

## Structure
- Package `logic_basic_cdc_pkg`:
  - state enum `cdc_tx_state_t` {IDLE, WAIT_ACK}, shared with the future receiver;
  - constant `CDC_MIN_STAGES` = 2, used in a parameter-legality check (elaboration-time `$error` if `STAGES < CDC_MIN_STAGES`).
- One sub-module: the existing `logic_basic_synchronizer` with WIDTH=1 and STAGES=`STAGES`, for `cdc_ack` → `ack_s`. No other synchronization in this block.

## Test plan
The bench uses WIDTH=8 and STAGES=2. Its ack model echoes `cdc_req` onto `cdc_ack` after N `aclk` cycles.

1. Reset, then idle for 10 cycles -> `tx_ready`=1, `cdc_req`=0, `cdc_data`=0x00, `err`=0 throughout.
2. Single transfer: `tx_data`=0xA5 with `tx_valid` for 1 cycle, ack echo N=3 -> `cdc_data`=0xA5 and `cdc_req`=1 after the accept edge. `tx_ready` is 0 until the edge 2 cycles after `cdc_ack` is first sampled high, then 1. `err`=0.
3. Streaming: `tx_valid` held high with 0x01, 0x02, 0x03 offered in turn -> exactly three accepts, each only when `tx_ready`=1. `cdc_req` sequence is 1, 0, 1. `cdc_data` never changes while in WAIT_ACK.
4. Spurious ack: toggle `cdc_ack` while IDLE -> `err`=1 three edges later (2 sync stages + 1), and it stays 1. A subsequent 0x5A transfer still completes.
5. Reset mid-transfer: accept 0xFF, assert `areset_n`=0 before the ack returns -> `cdc_req`=0, `cdc_data`=0x00 and `tx_ready`=1 immediately. With the ack model also reset, `err` stays 0.
6. Stalled destination: no ack for 1000 cycles -> `tx_ready` stays 0, `cdc_data` and `cdc_req` are unchanged, `err`=0.
